cv32e40p_if_id_queue: RTL and testbench

Parametrised IF-to-ID instruction queue that replaces the single-entry IF/ID pipeline register with a DEPTH-entry circular buffer. It sits between the prefetch/decompress logic of the IF stage and the ID stage. It decouples fetch from decode stalls with a valid/ready handshake on both sides. It keeps the existing flush (`clear_instr_valid_i`) and fetch-failed semantics.

---
 rtl/cv32e40p_if_id_queue_pkg.sv | 21 ++
 rtl/cv32e40p_if_id_queue_if.sv | 88 ++++++++
 rtl/cv32e40p_if_id_queue_perf_cnt.sv | 33 +++
 rtl/cv32e40p_if_id_queue.sv | 128 ++++++++++++
 tb/tb_cv32e40p_if_id_queue.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_if_id_queue_pkg.sv
// Shared types and constants for the IF-to-ID instruction queue.
// Optional feature macro used by this slice: CV32E40P_IF_QUEUE_PERF_EN.
package cv32e40p_pkg;

   // Largest supported queue depth.
   localparam int IF_QUEUE_MAX_DEPTH = 8;

   // One queued instruction as handed from IF to ID.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        compressed;
      logic        illegal_c;
   } if_id_entry_t;

   // Pointer width for a given depth; depth 1 still needs a one-bit pointer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/cv32e40p_if_id_queue_if.sv
// Handshake/bus bundle between the IF stage, the queue and the ID stage.
// With CV32E40P_IF_QUEUE_PERF_EN defined the bundle also carries the
// starvation and full-stall counters.
interface cv32e40p_if_id_queue_if #(
   parameter int DEPTH = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // IF side
   logic             fetch_valid_i;
   logic [31:0]      instr_decompressed_i;
   logic             instr_compressed_i;
   logic             illegal_c_insn_i;
   logic [31:0]      pc_if_i;
   logic             fetch_failed_i;
   logic             halt_if_i;
   logic             clear_instr_valid_i;
   logic             if_ready_o;
   logic             if_valid_o;

   // ID side
   logic             id_ready_i;
   logic             instr_valid_id_o;
   logic [31:0]      instr_rdata_id_o;
   logic [31:0]      pc_id_o;
   logic             is_compressed_id_o;
   logic             illegal_c_insn_id_o;
   logic             is_fetch_failed_o;
   logic [CNT_W-1:0] count_o;

`ifdef CV32E40P_IF_QUEUE_PERF_EN
   logic [31:0]      starve_cnt_o;
   logic [31:0]      full_cnt_o;
`endif

   // Queue side of the bundle
   modport slave (
`ifdef CV32E40P_IF_QUEUE_PERF_EN
      output starve_cnt_o,
      output full_cnt_o,
`endif
      input  fetch_valid_i,
      input  instr_decompressed_i,
      input  instr_compressed_i,
      input  illegal_c_insn_i,
      input  pc_if_i,
      input  fetch_failed_i,
      input  halt_if_i,
      input  clear_instr_valid_i,
      input  id_ready_i,
      output if_ready_o,
      output if_valid_o,
      output instr_valid_id_o,
      output instr_rdata_id_o,
      output pc_id_o,
      output is_compressed_id_o,
      output illegal_c_insn_id_o,
      output is_fetch_failed_o,
      output count_o
   );

   // Pipeline (IF/ID/controller) side of the bundle
   modport master (
`ifdef CV32E40P_IF_QUEUE_PERF_EN
      input  starve_cnt_o,
      input  full_cnt_o,
`endif
      output fetch_valid_i,
      output instr_decompressed_i,
      output instr_compressed_i,
      output illegal_c_insn_i,
      output pc_if_i,
      output fetch_failed_i,
      output halt_if_i,
      output clear_instr_valid_i,
      output id_ready_i,
      input  if_ready_o,
      input  if_valid_o,
      input  instr_valid_id_o,
      input  instr_rdata_id_o,
      input  pc_id_o,
      input  is_compressed_id_o,
      input  illegal_c_insn_id_o,
      input  is_fetch_failed_o,
      input  count_o
   );

endinterface

// File: rtl/cv32e40p_if_id_queue_perf_cnt.sv
// Saturating performance counters for the IF-to-ID queue.
// Only exists when CV32E40P_IF_QUEUE_PERF_EN is defined.
`ifdef CV32E40P_IF_QUEUE_PERF_EN
module cv32e40p_if_id_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        starve_inc,
   input  logic        full_inc,
   output logic [31:0] starve_cnt_o,
   output logic [31:0] full_cnt_o
);
   logic [1:0] inc;

   assign inc = {full_inc, starve_inc};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;

      // count events, holding at all-ones instead of wrapping
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_reg <= '0;
         end else if (inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
            cnt_reg <= cnt_reg + 32'd1;
         end
      end
   end

   assign starve_cnt_o = g_cnt[0].cnt_reg;
   assign full_cnt_o   = g_cnt[1].cnt_reg;

endmodule
`endif

// File: rtl/cv32e40p_if_id_queue.sv
// IF-to-ID instruction queue: a DEPTH-entry circular buffer replacing the
// single IF/ID pipeline register. Head outputs come straight from the slot
// at the read pointer, so an entry is visible the cycle after its push.
// Optional: CV32E40P_IF_QUEUE_PERF_EN adds starvation/full-stall counters.
module cv32e40p_if_id_queue
   import cv32e40p_pkg::*;
#(
   parameter int DEPTH = 2   // 1..IF_QUEUE_MAX_DEPTH
) (
   input logic                   clk,
   input logic                   rst_n,
   cv32e40p_if_id_queue_if.slave bus
);
   localparam int               PTR_W    = ptr_width(DEPTH);
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             fetch_failed_reg, fetch_failed_next;

   logic             instr_valid;
   logic             pop;
   logic             ready;
   logic             push;
   if_id_entry_t     new_entry;
   if_id_entry_t     head;
   if_id_entry_t     slots [DEPTH];

   // Handshake: a pop frees its slot in the same cycle, so a full queue can
   // still accept a push while the head is being consumed.
   assign instr_valid = (count_reg != '0);
   assign pop         = instr_valid & bus.id_ready_i;
   assign ready       = (count_reg < FULL_CNT) | pop;
   assign push        = bus.fetch_valid_i & ~bus.halt_if_i
                      & ~bus.clear_instr_valid_i & ready;

   assign new_entry = '{instr:      bus.instr_decompressed_i,
                        pc:         bus.pc_if_i,
                        compressed: bus.instr_compressed_i,
                        illegal_c:  bus.illegal_c_insn_i};

   // Storage: one register per slot, written only when it is the push target.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      if_id_entry_t slot_reg;

      // capture the pushed instruction into this slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_reg <= '0;
         end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
            slot_reg <= new_entry;
         end
      end

      assign slots[gi] = slot_reg;
   end

   assign head = slots[rd_ptr_reg];

   // Next-state for pointers, occupancy and the sticky fetch-failed flag;
   // a flush overrides any push or pop in the same cycle.
   always_comb begin
      rd_ptr_next       = rd_ptr_reg;
      wr_ptr_next       = wr_ptr_reg;
      count_next        = count_reg;
      fetch_failed_next = fetch_failed_reg;

      if (bus.clear_instr_valid_i) begin
         rd_ptr_next       = '0;
         wr_ptr_next       = '0;
         count_next        = '0;
         fetch_failed_next = bus.fetch_failed_i;
      end else begin
         if (push) begin
            wr_ptr_next       = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            fetch_failed_next = 1'b0;
         end
         if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
         end
         if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
         end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
         end
      end
   end

   // Queue control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg       <= '0;
         wr_ptr_reg       <= '0;
         count_reg        <= '0;
         fetch_failed_reg <= 1'b0;
      end else begin
         rd_ptr_reg       <= rd_ptr_next;
         wr_ptr_reg       <= wr_ptr_next;
         count_reg        <= count_next;
         fetch_failed_reg <= fetch_failed_next;
      end
   end

   assign bus.if_ready_o          = ready;
   assign bus.if_valid_o          = push;
   assign bus.instr_valid_id_o    = instr_valid;
   assign bus.instr_rdata_id_o    = head.instr;
   assign bus.pc_id_o             = head.pc;
   assign bus.is_compressed_id_o  = head.compressed;
   assign bus.illegal_c_insn_id_o = head.illegal_c;
   assign bus.is_fetch_failed_o   = fetch_failed_reg;
   assign bus.count_o             = count_reg;

`ifdef CV32E40P_IF_QUEUE_PERF_EN
   cv32e40p_if_id_perf_cnt i_perf_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .starve_inc   (bus.id_ready_i & ~instr_valid),
      .full_inc     (bus.fetch_valid_i & ~ready),
      .starve_cnt_o (bus.starve_cnt_o),
      .full_cnt_o   (bus.full_cnt_o)
   );
`endif

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// Self-checking bench for cv32e40p_if_id_queue: three instances (DEPTH 1, 2
// and 3) share one stimulus stream and are compared every cycle against a
// list-based reference model. Honours CV32E40P_IF_QUEUE_PERF_EN.
module tb_cv32e40p_if_id_queue;
   import cv32e40p_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // shared stimulus
   logic        fetch_valid  = 1'b0;
   logic [31:0] instr_word   = '0;
   logic        compressed   = 1'b0;
   logic        illegal      = 1'b0;
   logic [31:0] pc_val       = '0;
   logic        fetch_failed = 1'b0;
   logic        halt         = 1'b0;
   logic        clear        = 1'b0;
   logic        id_ready     = 1'b0;

   cv32e40p_if_id_queue_if #(.DEPTH(1)) bus1 ();
   cv32e40p_if_id_queue_if #(.DEPTH(2)) bus2 ();
   cv32e40p_if_id_queue_if #(.DEPTH(3)) bus3 ();

   assign bus1.fetch_valid_i = fetch_valid;   assign bus2.fetch_valid_i = fetch_valid;   assign bus3.fetch_valid_i = fetch_valid;
   assign bus1.instr_decompressed_i = instr_word; assign bus2.instr_decompressed_i = instr_word; assign bus3.instr_decompressed_i = instr_word;
   assign bus1.instr_compressed_i = compressed; assign bus2.instr_compressed_i = compressed; assign bus3.instr_compressed_i = compressed;
   assign bus1.illegal_c_insn_i = illegal;    assign bus2.illegal_c_insn_i = illegal;    assign bus3.illegal_c_insn_i = illegal;
   assign bus1.pc_if_i = pc_val;              assign bus2.pc_if_i = pc_val;              assign bus3.pc_if_i = pc_val;
   assign bus1.fetch_failed_i = fetch_failed; assign bus2.fetch_failed_i = fetch_failed; assign bus3.fetch_failed_i = fetch_failed;
   assign bus1.halt_if_i = halt;              assign bus2.halt_if_i = halt;              assign bus3.halt_if_i = halt;
   assign bus1.clear_instr_valid_i = clear;   assign bus2.clear_instr_valid_i = clear;   assign bus3.clear_instr_valid_i = clear;
   assign bus1.id_ready_i = id_ready;         assign bus2.id_ready_i = id_ready;         assign bus3.id_ready_i = id_ready;

   cv32e40p_if_id_queue #(.DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   cv32e40p_if_id_queue #(.DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   cv32e40p_if_id_queue #(.DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   // observed outputs, indexed 0..2 for DEPTH 1..3
   logic [2:0]  obs_ready, obs_push, obs_valid, obs_ff, obs_comp, obs_ill;
   logic [31:0] obs_pc [3];
   logic [31:0] obs_instr [3];
   logic [1:0]  obs_count [3];

   assign obs_ready = {bus3.if_ready_o, bus2.if_ready_o, bus1.if_ready_o};
   assign obs_push  = {bus3.if_valid_o, bus2.if_valid_o, bus1.if_valid_o};
   assign obs_valid = {bus3.instr_valid_id_o, bus2.instr_valid_id_o, bus1.instr_valid_id_o};
   assign obs_ff    = {bus3.is_fetch_failed_o, bus2.is_fetch_failed_o, bus1.is_fetch_failed_o};
   assign obs_comp  = {bus3.is_compressed_id_o, bus2.is_compressed_id_o, bus1.is_compressed_id_o};
   assign obs_ill   = {bus3.illegal_c_insn_id_o, bus2.illegal_c_insn_id_o, bus1.illegal_c_insn_id_o};
   assign obs_pc[0] = bus1.pc_id_o; assign obs_pc[1] = bus2.pc_id_o; assign obs_pc[2] = bus3.pc_id_o;
   assign obs_instr[0] = bus1.instr_rdata_id_o;
   assign obs_instr[1] = bus2.instr_rdata_id_o;
   assign obs_instr[2] = bus3.instr_rdata_id_o;
   assign obs_count[0] = {1'b0, bus1.count_o};
   assign obs_count[1] = bus2.count_o;
   assign obs_count[2] = bus3.count_o;

`ifdef CV32E40P_IF_QUEUE_PERF_EN
   logic [31:0] obs_starve [3];
   logic [31:0] obs_full [3];
   assign obs_starve[0] = bus1.starve_cnt_o; assign obs_starve[1] = bus2.starve_cnt_o; assign obs_starve[2] = bus3.starve_cnt_o;
   assign obs_full[0]   = bus1.full_cnt_o;   assign obs_full[1]   = bus2.full_cnt_o;   assign obs_full[2]   = bus3.full_cnt_o;
   int unsigned m_starve [3];
   int unsigned m_full [3];
`endif

   // reference model: ordered list of entries, head at index 0
   if_id_entry_t m_list [3][8];
   int           m_size [3];
   bit           m_ff [3];
   int           m_depth [3];

   int  n_checks = 0;
   int  n_pass   = 0;
   bit  verbose  = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_size[k] = 0;
         m_ff[k]   = 1'b0;
`ifdef CV32E40P_IF_QUEUE_PERF_EN
         m_starve[k] = 0;
         m_full[k]   = 0;
`endif
      end
   endtask

   // compare all outputs of every instance with the model's view of this cycle
   task automatic check_model();
      for (int k = 0; k < 3; k++) begin
         bit valid, pop, ready, push;
         valid = (m_size[k] > 0);
         pop   = valid && id_ready;
         ready = (m_size[k] < m_depth[k]) || pop;
         push  = fetch_valid && !halt && !clear && ready;
         check_eq($sformatf("d%0d.if_ready", k + 1), 64'(obs_ready[k]), 64'(ready));
         check_eq($sformatf("d%0d.if_valid", k + 1), 64'(obs_push[k]), 64'(push));
         check_eq($sformatf("d%0d.instr_valid", k + 1), 64'(obs_valid[k]), 64'(valid));
         check_eq($sformatf("d%0d.count", k + 1), 64'(obs_count[k]), 64'(m_size[k]));
         check_eq($sformatf("d%0d.fetch_failed", k + 1), 64'(obs_ff[k]), 64'(m_ff[k]));
         if (valid) begin
            check_eq($sformatf("d%0d.head_pc", k + 1), 64'(obs_pc[k]), 64'(m_list[k][0].pc));
            check_eq($sformatf("d%0d.head_instr", k + 1), 64'(obs_instr[k]), 64'(m_list[k][0].instr));
            check_eq($sformatf("d%0d.head_comp", k + 1), 64'(obs_comp[k]), 64'(m_list[k][0].compressed));
            check_eq($sformatf("d%0d.head_ill", k + 1), 64'(obs_ill[k]), 64'(m_list[k][0].illegal_c));
         end
`ifdef CV32E40P_IF_QUEUE_PERF_EN
         check_eq($sformatf("d%0d.starve_cnt", k + 1), 64'(obs_starve[k]), 64'(m_starve[k]));
         check_eq($sformatf("d%0d.full_cnt", k + 1), 64'(obs_full[k]), 64'(m_full[k]));
`endif
      end
   endtask

   // advance the model by one clock edge using the inputs held this cycle
   task automatic update_model();
      for (int k = 0; k < 3; k++) begin
         bit valid, pop, ready, push;
         valid = (m_size[k] > 0);
         pop   = valid && id_ready;
         ready = (m_size[k] < m_depth[k]) || pop;
         push  = fetch_valid && !halt && !clear && ready;
`ifdef CV32E40P_IF_QUEUE_PERF_EN
         if (id_ready && !valid && m_starve[k] != 32'hFFFF_FFFF) m_starve[k]++;
         if (fetch_valid && !ready && m_full[k] != 32'hFFFF_FFFF) m_full[k]++;
`endif
         if (clear) begin
            m_size[k] = 0;
            m_ff[k]   = fetch_failed;
         end else begin
            if (pop) begin
               for (int j = 0; j < 7; j++) m_list[k][j] = m_list[k][j + 1];
               m_size[k]--;
            end
            if (push) begin
               m_list[k][m_size[k]] = {instr_word, pc_val, compressed, illegal};
               m_size[k]++;
               m_ff[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic drive_cycle(input bit fv, input logic [31:0] p, input logic [31:0] ins,
                              input bit c, input bit il, input bit ffl, input bit h,
                              input bit clr, input bit rdy);
      @(negedge clk);
      fetch_valid = fv; pc_val = p; instr_word = ins; compressed = c; illegal = il;
      fetch_failed = ffl; halt = h; clear = clr; id_ready = rdy;
      #1;
      if (verbose)
         $display("t=%0t fv=%b pc=%h halt=%b clr=%b rdy=%b | acc d1/d2/d3=%b%b%b cnt=%0d/%0d/%0d",
                  $time, fv, p, h, clr, rdy, obs_push[0], obs_push[1], obs_push[2],
                  obs_count[0], obs_count[1], obs_count[2]);
      check_model();
   endtask

   task automatic end_cycle();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic do_cycle(input bit fv, input logic [31:0] p, input bit rdy);
      drive_cycle(fv, p, p ^ 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
      end_cycle();
   endtask

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("%s.d%0d.if_ready", tag, k + 1), 64'(obs_ready[k]), 64'd1);
         check_eq($sformatf("%s.d%0d.if_valid", tag, k + 1), 64'(obs_push[k]), 64'd0);
         check_eq($sformatf("%s.d%0d.instr_valid", tag, k + 1), 64'(obs_valid[k]), 64'd0);
         check_eq($sformatf("%s.d%0d.count", tag, k + 1), 64'(obs_count[k]), 64'd0);
         check_eq($sformatf("%s.d%0d.fetch_failed", tag, k + 1), 64'(obs_ff[k]), 64'd0);
         check_eq($sformatf("%s.d%0d.pc", tag, k + 1), 64'(obs_pc[k]), 64'd0);
         check_eq($sformatf("%s.d%0d.instr", tag, k + 1), 64'(obs_instr[k]), 64'd0);
         check_eq($sformatf("%s.d%0d.comp_ill", tag, k + 1), 64'({obs_comp[k], obs_ill[k]}), 64'd0);
      end
   endtask

   initial begin
      m_depth[0] = 1; m_depth[1] = 2; m_depth[2] = 3;
      model_reset();

      // reset state
      repeat (2) @(negedge clk);
      #1 check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle(1'b0, 32'h0, 1'b1);   // idle with id_ready on an empty queue

      // fill: 0x100/0x104/0x108 with ID stalled
      do_cycle(1'b1, 32'h100, 1'b0);
      do_cycle(1'b1, 32'h104, 1'b0);
      drive_cycle(1'b1, 32'h108, 32'h108 ^ 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("d2_third_if_ready", 64'(bus2.if_ready_o), 64'd0);
      check_eq("d2_third_if_valid", 64'(bus2.if_valid_o), 64'd0);
      end_cycle();
      check_eq("d2_full_count", 64'(bus2.count_o), 64'd2);
      check_eq("d2_full_head", 64'(bus2.pc_id_o), 64'h100);
      check_eq("d3_full_count", 64'(bus3.count_o), 64'd3);

      // DEPTH 3 full: push 0x200 while popping
      do_cycle(1'b1, 32'h200, 1'b1);
      check_eq("d3_pushpop_count", 64'(bus3.count_o), 64'd3);
      check_eq("d3_pushpop_head", 64'(bus3.pc_id_o), 64'h104);
      do_cycle(1'b0, 32'h0, 1'b1);
      do_cycle(1'b0, 32'h0, 1'b1);
      check_eq("d3_0x200_head", 64'(bus3.pc_id_o), 64'h200);

      // flush with fetch_failed alongside a valid push
      drive_cycle(1'b1, 32'h400, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      check_eq("flush_push_blocked", 64'(bus2.if_valid_o), 64'd0);
      end_cycle();
      check_eq("flush_count", 64'(bus2.count_o), 64'd0);
      check_eq("flush_valid", 64'(bus2.instr_valid_id_o), 64'd0);
      check_eq("flush_ff_set", 64'(bus2.is_fetch_failed_o), 64'd1);
      do_cycle(1'b0, 32'h0, 1'b0);
      do_cycle(1'b1, 32'h404, 1'b0);
      check_eq("push_clears_ff", 64'(bus2.is_fetch_failed_o), 64'd0);

      // halt with an empty queue
      do_cycle(1'b0, 32'h0, 1'b1);
      drive_cycle(1'b1, 32'h300, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("halt_if_valid", 64'(bus2.if_valid_o), 64'd0);
      end_cycle();
      check_eq("halt_empty", 64'(bus2.count_o), 64'd0);
      drive_cycle(1'b1, 32'h300, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("unhalt_if_valid", 64'(bus2.if_valid_o), 64'd1);
      end_cycle();
      check_eq("unhalt_head", 64'(bus2.pc_id_o), 64'h300);
      check_eq("unhalt_valid", 64'(bus2.instr_valid_id_o), 64'd1);
      repeat (3) do_cycle(1'b0, 32'h0, 1'b1);

      // compressed + illegal stream into DEPTH 1 with ID popping every cycle
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, 32'h500 + 32'(2 * i), 32'h0000_0013, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         check_eq($sformatf("d1_stream_accept%0d", i), 64'(bus1.if_valid_o), 64'd1);
         end_cycle();
         check_eq($sformatf("d1_stream_flags%0d", i),
                  64'({bus1.is_compressed_id_o, bus1.illegal_c_insn_id_o}), 64'd3);
      end
      repeat (4) do_cycle(1'b0, 32'h0, 1'b1);

      // randomized traffic
      verbose = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
         end_cycle();
      end
      verbose = 1'b1;

      // asynchronous reset in the middle of traffic
      do_cycle(1'b1, 32'h600, 1'b0);
      do_cycle(1'b1, 32'h604, 1'b0);
      @(negedge clk);
      fetch_valid = 1'b0; id_ready = 1'b0; halt = 1'b0; clear = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_state("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_cycle(1'b1, 32'h700, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
